// File: rtl/rst_seq_ctrl_if.sv
// Reset-sequencer control bundle.
// Carries the lock/request inputs into the sequencer and the staged reset,
// status and diagnostic outputs back out.
//   master : drives i_pll_locked_sync, i_sw_reset_req, i_fault_clear;
//            observes o_stage_rst, o_all_released, o_motor_safe, o_fault,
//            o_state, o_loss_count
//   slave  : the sequencer itself (rst_seq_ctrl)
interface rst_seq_ctrl_if #(
   parameter int NUM_STAGES = 4
);
   logic                  i_pll_locked_sync;
   logic                  i_sw_reset_req;
   logic                  i_fault_clear;
   logic [NUM_STAGES-1:0] o_stage_rst;
   logic                  o_all_released;
   logic                  o_motor_safe;
   logic                  o_fault;
   logic [2:0]            o_state;
   logic [7:0]            o_loss_count;

   modport master (
      output i_pll_locked_sync, i_sw_reset_req, i_fault_clear,
      input  o_stage_rst, o_all_released, o_motor_safe, o_fault, o_state, o_loss_count
   );

   modport slave (
      input  i_pll_locked_sync, i_sw_reset_req, i_fault_clear,
      output o_stage_rst, o_all_released, o_motor_safe, o_fault, o_state, o_loss_count
   );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer and PLL-lock supervisor, 27 MHz input-clock domain.
// Releases NUM_STAGES active-high resets in index order once the PLL lock is
// qualified, re-sequences (drains) on a filtered lock loss or a software
// request, and latches a fault after FAULT_LIMIT lock losses.
// Ports:
//   i_clk          : 27 MHz input clock
//   por_reset_27m  : asynchronous, active-high power-on reset
//   bus (slave)    : lock/request inputs, staged resets and status outputs
//
// state   | meaning
// --------+------------------------------------------------------------
// HOLD    | all stage resets asserted, waiting for qualified lock
// RELEASE | stages 0..stg released, gap timer running toward stg+1
// RUN     | all stages released, motor path enabled
// DRAIN   | re-asserting released stages, highest index first
// FAULT   | too many lock losses; everything held until fault clear
module rst_seq_ctrl #(
   parameter int NUM_STAGES      = 4,
   parameter int STAGE_GAP_CYC   = 2700,
   parameter int LOCK_FILTER_CYC = 27,
   parameter int FAULT_LIMIT     = 3,
   parameter int CNT_W           = 16
) (
   input  logic          i_clk,
   input  logic          por_reset_27m,
   rst_seq_ctrl_if.slave bus
);

   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [CNT_W-1:0] GAP_TC    = CNT_W'(STAGE_GAP_CYC - 1);
   localparam logic [CNT_W-1:0] FILT_TC   = CNT_W'(LOCK_FILTER_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [7:0]       FC_LIMIT  = 8'(FAULT_LIMIT);

   typedef enum logic [2:0] {
      S_HOLD    = 3'd0,
      S_RELEASE = 3'd1,
      S_RUN     = 3'd2,
      S_DRAIN   = 3'd3,
      S_FAULT   = 3'd4
   } state_t;

   state_t                state;
   logic [NUM_STAGES-1:0] stage_rst;
   logic                  all_released;
   logic                  motor_safe;
   logic                  fault;
   logic [7:0]            loss_count;
   logic [7:0]            fault_cnt;
   logic [7:0]            fault_cnt_nxt;
   logic [CNT_W-1:0]      hi_cnt;
   logic [CNT_W-1:0]      lo_cnt;
   logic [CNT_W-1:0]      gap_cnt;
   logic                  lock_q;
   logic                  lock_set;
   logic                  loss_evt;
   logic                  leave_req;
   logic [IDX_W-1:0]      stg;
   logic [IDX_W-1:0]      stg_inc;

   always_comb begin
      lock_set  = !lock_q && bus.i_pll_locked_sync && (hi_cnt == GAP_TC);
      loss_evt  = lock_q && !bus.i_pll_locked_sync && (lo_cnt == FILT_TC);
      leave_req = loss_evt || bus.i_sw_reset_req;
      stg_inc   = stg + IDX_ONE;
      // Clear wins over a coincident loss so an acknowledged fault starts fresh.
      fault_cnt_nxt = fault_cnt;
      if ((state == S_FAULT) && bus.i_fault_clear)
         fault_cnt_nxt = '0;
      else if (loss_evt && (fault_cnt != 8'hFF))
         fault_cnt_nxt = fault_cnt + 8'd1;
   end

   always_ff @(posedge i_clk or posedge por_reset_27m) begin
      if (por_reset_27m) begin
         state        <= S_HOLD;
         stage_rst    <= '1;
         all_released <= 1'b0;
         motor_safe   <= 1'b1;
         fault        <= 1'b0;
         loss_count   <= '0;
         fault_cnt    <= '0;
         hi_cnt       <= '0;
         lo_cnt       <= '0;
         gap_cnt      <= '0;
         lock_q       <= 1'b0;
         stg          <= '0;
      end else begin
         // Lock qualifier while unlocked, low-run filter while locked.
         if (lock_q) begin
            hi_cnt <= '0;
            if (bus.i_pll_locked_sync) begin
               lo_cnt <= '0;
            end else if (loss_evt) begin
               lo_cnt <= '0;
               lock_q <= 1'b0;
            end else begin
               lo_cnt <= lo_cnt + CNT_ONE;
            end
         end else begin
            lo_cnt <= '0;
            if (!bus.i_pll_locked_sync) begin
               hi_cnt <= '0;
            end else if (lock_set) begin
               hi_cnt <= '0;
               lock_q <= 1'b1;
            end else begin
               hi_cnt <= hi_cnt + CNT_ONE;
            end
         end

         if (loss_evt && (loss_count != 8'hFF))
            loss_count <= loss_count + 8'd1;
         fault_cnt <= fault_cnt_nxt;

         case (state)
            S_HOLD: begin
               // lock_q may already be set (sw re-sequence): release at once.
               if (lock_set || (lock_q && !loss_evt)) begin
                  stage_rst[0] <= 1'b0;
                  stg          <= '0;
                  gap_cnt      <= GAP_TC;
                  if (LAST_IDX == '0) begin
                     state        <= S_RUN;
                     all_released <= 1'b1;
                     motor_safe   <= 1'b0;
                  end else begin
                     state <= S_RELEASE;
                  end
               end
            end
            S_RELEASE: begin
               if (leave_req) begin
                  state <= S_DRAIN;
               end else if (gap_cnt == '0) begin
                  stage_rst[stg_inc] <= 1'b0;
                  stg                <= stg_inc;
                  gap_cnt            <= GAP_TC;
                  if (stg_inc == LAST_IDX) begin
                     state        <= S_RUN;
                     all_released <= 1'b1;
                     motor_safe   <= 1'b0;
                  end
               end else begin
                  gap_cnt <= gap_cnt - CNT_ONE;
               end
            end
            S_RUN: begin
               if (leave_req) begin
                  state        <= S_DRAIN;
                  all_released <= 1'b0;
                  motor_safe   <= 1'b1;
               end
            end
            S_DRAIN: begin
               // stg tracks the highest released stage.
               stage_rst[stg] <= 1'b1;
               if (stg == '0) begin
                  if (fault_cnt_nxt >= FC_LIMIT) begin
                     state <= S_FAULT;
                     fault <= 1'b1;
                  end else begin
                     state <= S_HOLD;
                  end
               end else begin
                  stg <= stg - IDX_ONE;
               end
            end
            S_FAULT: begin
               stage_rst <= '1;
               if (bus.i_fault_clear) begin
                  state <= S_HOLD;
                  fault <= 1'b0;
               end
            end
            default: begin
               state     <= S_HOLD;
               stage_rst <= '1;
            end
         endcase
      end
   end

   assign bus.o_stage_rst    = stage_rst;
   assign bus.o_all_released = all_released;
   assign bus.o_motor_safe   = motor_safe;
   assign bus.o_fault        = fault;
   assign bus.o_state        = state;
   assign bus.o_loss_count   = loss_count;

endmodule
